// File: rtl/audio_song_sequencer_if.sv
// Pattern ROM read port shared by the melody and bass fetches of audio_song_sequencer.
// Handshake: rom_rd is a one-cycle read strobe with rom_addr valid alongside it;
// the ROM must present rom_data exactly one cycle later. There is no ready or
// back-pressure, and at most one read is outstanding.
interface audio_song_sequencer_if #(
    parameter int POS_W = 9
);
    logic             rom_rd;
    logic [POS_W:0]   rom_addr;
    logic [5:0]       rom_data;

    modport master (output rom_rd, output rom_addr, input rom_data);
    modport slave  (input rom_rd, input rom_addr, output rom_data);
endinterface

// File: rtl/audio_song_sequencer.sv
// Frame-tick driven song scheduler: counts ticks into beats, fetches melody and bass
// entries from the pattern ROM, and applies per-tick volume decay to both voices.
module audio_song_sequencer #(
    parameter int SONG_LEN       = 288,
    parameter int TICKS_PER_BEAT = 6,
    parameter int POS_W          = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   tick_stb,
    audio_song_sequencer_if.master rom,
    output logic [2:0]             mel_note,
    output logic [1:0]             mel_oct,
    output logic [2:0]             bass_note,
    output logic [1:0]             bass_oct,
    output logic [5:0]             mel_vol,
    output logic [5:0]             bass_vol,
    output logic [POS_W-1:0]       songpos,
    output logic                   beat_stb,
    output logic                   busy,
    output logic                   overrun,
    output logic [2:0]             state_dbg
);
    localparam int CTR_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(TICKS_PER_BEAT - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_MEL    = 3'd1,
        WAIT_MEL  = 3'd2,
        RD_BASS   = 3'd3,
        WAIT_BASS = 3'd4,
        COMMIT    = 3'd5
    } state_t;

    state_t           state;
    logic [CTR_W-1:0] beat_ctr;
    logic [5:0]       mel_shadow;
    logic [5:0]       bass_shadow;
    logic [POS_W-1:0] next_pos;
    logic             tick_ok;

    assign next_pos = (songpos == POS_LAST) ? '0 : songpos + 1'b1;
    assign tick_ok  = tick_stb & enable;

    // ROM port is a pure decode of the state register so reads line up with RD_* states.
    assign rom.rom_rd   = (state == RD_MEL) || (state == RD_BASS);
    assign rom.rom_addr = (state == RD_MEL)  ? {1'b0, next_pos} :
                          (state == RD_BASS) ? {1'b1, next_pos} : '0;
    assign busy         = (state != IDLE);
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat_ctr    <= CTR_LAST;
            songpos     <= POS_LAST;
            mel_shadow  <= '0;
            bass_shadow <= '0;
            mel_note    <= '0;
            mel_oct     <= '0;
            bass_note   <= '0;
            bass_oct    <= '0;
            mel_vol     <= '0;
            bass_vol    <= '0;
            beat_stb    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            beat_stb <= 1'b0;
            overrun  <= tick_ok && (state != IDLE);
            case (state)
                IDLE: begin
                    if (tick_ok) begin
                        if (beat_ctr == CTR_LAST) begin
                            beat_ctr <= '0;
                            state    <= RD_MEL;
                        end else begin
                            beat_ctr <= beat_ctr + 1'b1;
                            mel_vol  <= mel_vol - (mel_vol >> 3);
                            bass_vol <= bass_vol - (bass_vol >> 2);
                        end
                    end
                end
                RD_MEL:   state <= WAIT_MEL;
                WAIT_MEL: begin
                    mel_shadow <= rom.rom_data;
                    state      <= RD_BASS;
                end
                RD_BASS:  state <= WAIT_BASS;
                WAIT_BASS: begin
                    bass_shadow <= rom.rom_data;
                    state       <= COMMIT;
                end
                COMMIT: begin
                    // Beat ticks never decay; a trigger restarts the envelope at full scale.
                    songpos   <= next_pos;
                    mel_note  <= mel_shadow[2:0];
                    mel_oct   <= mel_shadow[4:3];
                    bass_note <= bass_shadow[2:0];
                    bass_oct  <= bass_shadow[4:3];
                    if (mel_shadow[5])  mel_vol  <= 6'd63;
                    if (bass_shadow[5]) bass_vol <= 6'd63;
                    beat_stb  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_song_sequencer.sv
// Directed self-checking bench for audio_song_sequencer with a 1-cycle-latency ROM model.
module tb_audio_song_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       tick_stb = 1'b0;
    logic [2:0] mel_note, bass_note, state_dbg;
    logic [1:0] mel_oct, bass_oct;
    logic [5:0] mel_vol, bass_vol;
    logic [8:0] songpos;
    logic       beat_stb, busy, overrun;

    logic [5:0]  rom [0:1023];
    logic [19:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    audio_song_sequencer_if #(.POS_W(9)) rif ();

    audio_song_sequencer #(.SONG_LEN(288), .TICKS_PER_BEAT(6), .POS_W(9)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick_stb(tick_stb), .rom(rif),
        .mel_note(mel_note), .mel_oct(mel_oct), .bass_note(bass_note), .bass_oct(bass_oct),
        .mel_vol(mel_vol), .bass_vol(bass_vol), .songpos(songpos), .beat_stb(beat_stb),
        .busy(busy), .overrun(overrun), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rif.rom_rd) rif.rom_data <= rom[rif.rom_addr];
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tick_stb = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One tick, then a fixed 7-cycle observation window covering a full fetch.
    task automatic run_tick(output int reads, output logic [9:0] a0, output logic [9:0] a1,
                            output int beats);
        tick_stb = 1'b1;
        @(negedge clk);
        tick_stb = 1'b0;
        reads = 0; beats = 0; a0 = '0; a1 = '0;
        for (int i = 0; i < 7; i++) begin
            if (rif.rom_rd) begin
                if (reads == 0) a0 = rif.rom_addr;
                else a1 = rif.rom_addr;
                reads++;
            end
            if (beat_stb) beats++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (songpos !== 9'd287) $display("FAIL reset_songpos: got %0d expected 287", songpos);
        else n_pass++;
        n_checks++;
        if ({mel_note, mel_oct, bass_note, bass_oct, mel_vol, bass_vol} !== 22'd0)
            $display("FAIL reset_voices: got %h expected 0",
                     {mel_note, mel_oct, bass_note, bass_oct, mel_vol, bass_vol});
        else n_pass++;
        n_checks++;
        if ({rif.rom_rd, beat_stb, busy, overrun, state_dbg} !== 7'd0)
            $display("FAIL reset_ctrl: got %b expected 0",
                     {rif.rom_rd, beat_stb, busy, overrun, state_dbg});
        else n_pass++;
    endtask

    task automatic test_first_beat();
        rom[0] = 6'h2B;
        rom[10'h200] = 6'h01;
        do_reset();
        tick_stb = 1'b1;
        @(negedge clk);
        tick_stb = 1'b0;
        n_checks++;
        if ({rif.rom_rd, busy, rif.rom_addr} !== {2'b11, 10'h000})
            $display("FAIL first_rd_mel: got rd=%b busy=%b addr=%h expected 1 1 000",
                     rif.rom_rd, busy, rif.rom_addr);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rif.rom_rd, rif.rom_addr} !== {1'b1, 10'h200})
            $display("FAIL first_rd_bass: got rd=%b addr=%h expected 1 200", rif.rom_rd, rif.rom_addr);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({songpos, beat_stb, busy} !== {9'd287, 2'b01})
            $display("FAIL first_commit_pending: got pos=%0d stb=%b busy=%b expected 287 0 1",
                     songpos, beat_stb, busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({songpos, mel_note, mel_oct, mel_vol} !== {9'd0, 3'd3, 2'd1, 6'd63})
            $display("FAIL first_mel: got pos=%0d note=%0d oct=%0d vol=%0d expected 0 3 1 63",
                     songpos, mel_note, mel_oct, mel_vol);
        else n_pass++;
        n_checks++;
        if ({bass_note, bass_oct, bass_vol, beat_stb, busy} !== {3'd1, 2'd0, 6'd0, 2'b10})
            $display("FAIL first_bass: got note=%0d oct=%0d vol=%0d stb=%b busy=%b expected 1 0 0 1 0",
                     bass_note, bass_oct, bass_vol, beat_stb, busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (beat_stb !== 1'b0) $display("FAIL first_stb_width: got %b expected 0", beat_stb);
        else n_pass++;
    endtask

    task automatic test_decay();
        int          reads, beats;
        logic [9:0]  a0, a1;
        logic [5:0]  exp_mel [5] = '{6'd56, 6'd49, 6'd43, 6'd38, 6'd34};
        logic [5:0]  exp_bass[5] = '{6'd48, 6'd36, 6'd27, 6'd21, 6'd16};
        rom[0] = 6'h2B; rom[10'h200] = 6'h21;
        rom[1] = 6'h05; rom[10'h201] = 6'h03;
        do_reset();
        run_tick(reads, a0, a1, beats);
        n_checks++;
        if ({beats, mel_vol, bass_vol} !== {32'd1, 6'd63, 6'd63})
            $display("FAIL decay_start: got beats=%0d mel=%0d bass=%0d expected 1 63 63",
                     beats, mel_vol, bass_vol);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            run_tick(reads, a0, a1, beats);
            n_checks++;
            if ({reads, mel_vol, bass_vol} !== {32'd0, exp_mel[k], exp_bass[k]})
                $display("FAIL decay_%0d: got reads=%0d mel=%0d bass=%0d expected 0 %0d %0d",
                         k, reads, mel_vol, bass_vol, exp_mel[k], exp_bass[k]);
            else n_pass++;
        end
        run_tick(reads, a0, a1, beats);
        n_checks++;
        if ({reads, a0, a1, songpos} !== {32'd2, 10'h001, 10'h201, 9'd1})
            $display("FAIL decay_sixth_fetch: got reads=%0d a0=%h a1=%h pos=%0d expected 2 001 201 1",
                     reads, a0, a1, songpos);
        else n_pass++;
        n_checks++;
        if ({mel_note, bass_note, mel_vol, bass_vol} !== {3'd5, 3'd3, 6'd34, 6'd16})
            $display("FAIL decay_hold_no_trig: got mn=%0d bn=%0d mel=%0d bass=%0d expected 5 3 34 16",
                     mel_note, bass_note, mel_vol, bass_vol);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int          reads, beats;
        logic [9:0]  a0, a1;
        logic [8:0]  pos;
        logic [19:0] exp_addr;
        for (int i = 0; i < 1024; i++) rom[i] = 6'($urandom_range(0, 63));
        do_reset();
        for (int b = 0; b <= 288; b++) begin
            pos = (b == 288) ? 9'd0 : 9'(b);
            exp_q.push_back({1'b0, pos, 1'b1, pos});
            run_tick(reads, a0, a1, beats);
            exp_addr = exp_q.pop_front();
            n_checks++;
            if ({a0, a1, songpos, mel_note, mel_oct, bass_note, bass_oct} !==
                {exp_addr, pos, rom[{1'b0, pos}][2:0], rom[{1'b0, pos}][4:3],
                 rom[{1'b1, pos}][2:0], rom[{1'b1, pos}][4:3]})
                $display("FAIL wrap_beat_%0d: got a0=%h a1=%h pos=%0d mel=%h bass=%h",
                         b, a0, a1, songpos, {mel_oct, mel_note}, {bass_oct, bass_note});
            else n_pass++;
            if (b < 288) repeat (5) run_tick(reads, a0, a1, beats);
        end
    endtask

    task automatic test_overrun();
        int          reads, beats, ov, bs, tot;
        logic [9:0]  a0, a1;
        do_reset();
        tick_stb = 1'b1;
        @(negedge clk);
        tick_stb = 1'b0;
        @(negedge clk);
        tick_stb = 1'b1;
        @(negedge clk);
        tick_stb = 1'b0;
        ov = 0; bs = 0;
        for (int i = 0; i < 8; i++) begin
            if (overrun) ov++;
            if (beat_stb) bs++;
            @(negedge clk);
        end
        n_checks++;
        if ({ov, bs, songpos} !== {32'd1, 32'd1, 9'd0})
            $display("FAIL overrun_pulse: got ov=%0d beats=%0d pos=%0d expected 1 1 0", ov, bs, songpos);
        else n_pass++;
        tot = 0;
        repeat (5) begin
            run_tick(reads, a0, a1, beats);
            tot += reads;
        end
        n_checks++;
        if (tot !== 0) $display("FAIL overrun_ctr_decay: got reads=%0d expected 0", tot);
        else n_pass++;
        run_tick(reads, a0, a1, beats);
        n_checks++;
        if ({reads, songpos} !== {32'd2, 9'd1})
            $display("FAIL overrun_ctr_fetch: got reads=%0d pos=%0d expected 2 1", reads, songpos);
        else n_pass++;
    endtask

    task automatic test_enable();
        int          reads, beats, tot_r, tot_b;
        logic [9:0]  a0, a1;
        do_reset();
        enable = 1'b0;
        tot_r = 0; tot_b = 0;
        repeat (10) begin
            run_tick(reads, a0, a1, beats);
            tot_r += reads;
            tot_b += beats;
        end
        n_checks++;
        if ({tot_r, tot_b, songpos, mel_note, mel_oct, bass_note, bass_oct, mel_vol, bass_vol, busy} !==
            {32'd0, 32'd0, 9'd287, 23'd0})
            $display("FAIL enable_off: got reads=%0d beats=%0d pos=%0d mv=%0d bv=%0d busy=%b",
                     tot_r, tot_b, songpos, mel_vol, bass_vol, busy);
        else n_pass++;
        enable = 1'b1;
        run_tick(reads, a0, a1, beats);
        n_checks++;
        if ({beats, songpos} !== {32'd1, 9'd0})
            $display("FAIL enable_on: got beats=%0d pos=%0d expected 1 0", beats, songpos);
        else n_pass++;
        repeat (5) run_tick(reads, a0, a1, beats);
        tick_stb = 1'b1;
        @(negedge clk);
        tick_stb = 1'b0;
        enable = 1'b0;
        tot_b = 0;
        for (int i = 0; i < 7; i++) begin
            if (beat_stb) tot_b++;
            @(negedge clk);
        end
        n_checks++;
        if ({tot_b, songpos, busy} !== {32'd1, 9'd1, 1'b0})
            $display("FAIL enable_drop_midfetch: got beats=%0d pos=%0d busy=%b expected 1 1 0",
                     tot_b, songpos, busy);
        else n_pass++;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_fetch();
        int          reads, beats;
        logic [9:0]  a0, a1;
        rom[0] = 6'h2B; rom[10'h200] = 6'h21;
        rom[1] = 6'h3F; rom[10'h201] = 6'h3E;
        do_reset();
        repeat (6) run_tick(reads, a0, a1, beats);
        tick_stb = 1'b1;
        @(negedge clk);
        tick_stb = 1'b0;
        for (int i = 0; i < 6 && state_dbg != 3'd4; i++) @(negedge clk);
        n_checks++;
        if ({state_dbg, songpos, mel_note} !== {3'd4, 9'd0, 3'd3})
            $display("FAIL rstmid_reach_wait_bass: got st=%0d pos=%0d mn=%0d expected 4 0 3",
                     state_dbg, songpos, mel_note);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({songpos, mel_note, mel_oct, bass_note, bass_oct, mel_vol, bass_vol,
             rif.rom_rd, beat_stb, busy, overrun, state_dbg} !== {9'd287, 29'd0})
            $display("FAIL rstmid_values: got pos=%0d mn=%0d bn=%0d mv=%0d bv=%0d st=%0d busy=%b",
                     songpos, mel_note, bass_note, mel_vol, bass_vol, state_dbg, busy);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_tick(reads, a0, a1, beats);
        n_checks++;
        if ({reads, a0, a1, songpos, mel_note, bass_vol} !== {32'd2, 10'h000, 10'h200, 9'd0, 3'd3, 6'd63})
            $display("FAIL rstmid_refetch: got reads=%0d a0=%h a1=%h pos=%0d mn=%0d bv=%0d",
                     reads, a0, a1, songpos, mel_note, bass_vol);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = '0;
        rif.rom_data = '0;
        test_reset();
        test_first_beat();
        test_decay();
        test_wrap();
        test_overrun();
        test_enable();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
